// File: rtl/sram_arbiter_if.sv
// Bus bundle between the SRAM arbiter, its two requesters and the SRAM pin wrapper.
// master: the environment side (video engine, host port, SRAM wrapper).
// slave:  the arbiter itself.
interface sram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    // Video line-fetch requester (read only)
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_rvalid;

    // Host/blitter requester (read or byte-masked write)
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [1:0]        host_be;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    // SRAM side, active-high strobes
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_ce;
    logic              ram_oe;
    logic              ram_we;
    logic              ram_lb;
    logic              ram_hb;

    modport master (
        output vid_req, vid_addr,
        input  vid_ack, vid_rdata, vid_rvalid,
        output host_req, host_we, host_addr, host_wdata, host_be,
        input  host_ack, host_rdata, host_rvalid,
        input  ram_addr, ram_dout, ram_ce, ram_oe, ram_we, ram_lb, ram_hb,
        output ram_din
    );

    modport slave (
        input  vid_req, vid_addr,
        output vid_ack, vid_rdata, vid_rvalid,
        input  host_req, host_we, host_addr, host_wdata, host_be,
        output host_ack, host_rdata, host_rvalid,
        output ram_addr, ram_dout, ram_ce, ram_oe, ram_we, ram_lb, ram_hb,
        input  ram_din
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for the single external 16-bit SRAM.
// Video reads have priority; the host is guaranteed a grant after
// MAX_VID_BURST consecutive video grants made while it was waiting.
// Every access is followed by at least one idle cycle with all strobes low.
module sram_arbiter #(
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_VID_BURST = 8
) (
    input  logic          clk100,
    input  logic          reset_n,
    sram_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] VID_RD  = 2'd1;
    localparam logic [1:0] HOST_RD = 2'd2;
    localparam logic [1:0] HOST_WR = 2'd3;

    localparam logic [3:0] LAST_CYCLE  = 4'(ACCESS_CYCLES);
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_VID_BURST);

    logic [1:0]        state_reg;
    logic [3:0]        cycle_reg;
    logic [7:0]        starve_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] dout_reg;
    logic [DATA_W-1:0] vid_rdata_reg;
    logic [DATA_W-1:0] host_rdata_reg;
    logic              vid_ack_reg;
    logic              host_ack_reg;
    logic              vid_rvalid_reg;
    logic              host_rvalid_reg;
    logic              ce_reg;
    logic              oe_reg;
    logic              we_reg;
    logic              lb_reg;
    logic              hb_reg;

    logic grant_ok;
    logic host_wins;
    logic host_null_write;
    logic last_cycle;

    // Grant decision. No grant is made while an ack is still on the wire in
    // IDLE (only possible after a be=00 write), so a requester that drops its
    // request on seeing the ack is not granted a second time.
    always_comb begin
        grant_ok        = (state_reg == IDLE) && !host_ack_reg;
        host_wins       = bus.host_req && (!bus.vid_req || (starve_reg == BURST_LIMIT));
        host_null_write = bus.host_we && (bus.host_be == 2'b00);
        last_cycle      = (cycle_reg == LAST_CYCLE);
    end

    // Arbitration, access sequencing, read capture and starvation counting.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            cycle_reg       <= '0;
            starve_reg      <= '0;
            addr_reg        <= '0;
            dout_reg        <= '0;
            vid_rdata_reg   <= '0;
            host_rdata_reg  <= '0;
            vid_ack_reg     <= 1'b0;
            host_ack_reg    <= 1'b0;
            vid_rvalid_reg  <= 1'b0;
            host_rvalid_reg <= 1'b0;
            ce_reg          <= 1'b0;
            oe_reg          <= 1'b0;
            we_reg          <= 1'b0;
            lb_reg          <= 1'b0;
            hb_reg          <= 1'b0;
        end else begin
            vid_ack_reg     <= 1'b0;
            host_ack_reg    <= 1'b0;
            vid_rvalid_reg  <= 1'b0;
            host_rvalid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!bus.host_req) begin
                        starve_reg <= '0;
                    end
                    if (grant_ok && host_wins) begin
                        host_ack_reg <= 1'b1;
                        starve_reg   <= '0;
                        // A write with no byte lanes is acknowledged but never reaches the SRAM.
                        if (!host_null_write) begin
                            state_reg <= bus.host_we ? HOST_WR : HOST_RD;
                            cycle_reg <= 4'd1;
                            addr_reg  <= bus.host_addr;
                            ce_reg    <= 1'b1;
                            oe_reg    <= !bus.host_we;
                            we_reg    <= bus.host_we;
                            lb_reg    <= bus.host_we ? bus.host_be[0] : 1'b1;
                            hb_reg    <= bus.host_we ? bus.host_be[1] : 1'b1;
                            if (bus.host_we) begin
                                dout_reg <= bus.host_wdata;
                            end
                        end
                    end else if (grant_ok && bus.vid_req) begin
                        vid_ack_reg <= 1'b1;
                        state_reg   <= VID_RD;
                        cycle_reg   <= 4'd1;
                        addr_reg    <= bus.vid_addr;
                        ce_reg      <= 1'b1;
                        oe_reg      <= 1'b1;
                        we_reg      <= 1'b0;
                        lb_reg      <= 1'b1;
                        hb_reg      <= 1'b1;
                        if (bus.host_req && (starve_reg != BURST_LIMIT)) begin
                            starve_reg <= starve_reg + 8'd1;
                        end
                    end
                end
                default: begin
                    if (last_cycle) begin
                        // End of access: drop strobes, capture read data at this edge.
                        state_reg <= IDLE;
                        ce_reg    <= 1'b0;
                        oe_reg    <= 1'b0;
                        we_reg    <= 1'b0;
                        lb_reg    <= 1'b0;
                        hb_reg    <= 1'b0;
                        if (state_reg == VID_RD) begin
                            vid_rdata_reg  <= bus.ram_din;
                            vid_rvalid_reg <= 1'b1;
                        end
                        if (state_reg == HOST_RD) begin
                            host_rdata_reg  <= bus.ram_din;
                            host_rvalid_reg <= 1'b1;
                        end
                    end else begin
                        cycle_reg <= cycle_reg + 4'd1;
                    end
                end
            endcase
        end
    end

    assign bus.vid_ack     = vid_ack_reg;
    assign bus.vid_rdata   = vid_rdata_reg;
    assign bus.vid_rvalid  = vid_rvalid_reg;
    assign bus.host_ack    = host_ack_reg;
    assign bus.host_rdata  = host_rdata_reg;
    assign bus.host_rvalid = host_rvalid_reg;
    assign bus.ram_addr    = addr_reg;
    assign bus.ram_dout    = dout_reg;
    assign bus.ram_ce      = ce_reg;
    assign bus.ram_oe      = oe_reg;
    assign bus.ram_we      = we_reg;
    assign bus.ram_lb      = lb_reg;
    assign bus.ram_hb      = hb_reg;
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed timing checks plus a
// randomized phase checked against a shadow-memory / access-window model,
// and two extra instances (ACCESS_CYCLES = 1 and 4) for spacing/latency.
module tb_sram_arbiter;
    localparam int AW   = 18;
    localparam int DW   = 16;
    localparam int AC   = 2;
    localparam int MAXB = 8;

    logic clk100  = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk100 = ~clk100;

    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b4 ();

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC), .MAX_VID_BURST(MAXB))
        dut (.clk100(clk100), .reset_n(reset_n), .bus(b0));
    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1), .MAX_VID_BURST(MAXB))
        dut_ac1 (.clk100(clk100), .reset_n(reset_n), .bus(b1));
    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(4), .MAX_VID_BURST(MAXB))
        dut_ac4 (.clk100(clk100), .reset_n(reset_n), .bus(b4));

    // External SRAM behaviour for the main instance (32 words decoded).
    logic [15:0] mem [32];
    always @(posedge clk100) begin
        if (b0.ram_ce && b0.ram_we) begin
            if (b0.ram_lb) mem[b0.ram_addr[4:0]][7:0]  <= b0.ram_dout[7:0];
            if (b0.ram_hb) mem[b0.ram_addr[4:0]][15:8] <= b0.ram_dout[15:8];
        end
    end
    assign b0.ram_din = (b0.ram_ce && b0.ram_oe) ? mem[b0.ram_addr[4:0]] : 16'hDEAD;

    // Side instances: read-only SRAM whose content is a fixed function of the address.
    logic        req_a [2];
    logic [17:0] addr_a [2];
    logic [1:0]  ackv;
    logic [1:0]  rv;
    logic [15:0] rd [2];
    assign b1.vid_req    = req_a[0];
    assign b4.vid_req    = req_a[1];
    assign b1.vid_addr   = addr_a[0];
    assign b4.vid_addr   = addr_a[1];
    assign b1.host_req   = 1'b0;
    assign b4.host_req   = 1'b0;
    assign b1.host_we    = 1'b0;
    assign b4.host_we    = 1'b0;
    assign b1.host_addr  = '0;
    assign b4.host_addr  = '0;
    assign b1.host_wdata = '0;
    assign b4.host_wdata = '0;
    assign b1.host_be    = 2'b00;
    assign b4.host_be    = 2'b00;
    assign b1.ram_din    = (b1.ram_ce && b1.ram_oe) ? (b1.ram_addr[15:0] ^ 16'hC3C3) : 16'h0000;
    assign b4.ram_din    = (b4.ram_ce && b4.ram_oe) ? (b4.ram_addr[15:0] ^ 16'hC3C3) : 16'h0000;
    assign ackv  = {b4.vid_ack, b1.vid_ack};
    assign rv    = {b4.vid_rvalid, b1.vid_rvalid};
    assign rd[0] = b1.vid_rdata;
    assign rd[1] = b4.vid_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [15:0] shadow [32];
    int          streak, win_end, exp_v_cyc, exp_h_cyc, n, m, nv, nh, got;
    logic [4:0]  win_s, es;
    logic [17:0] win_addr;
    logic [15:0] win_dout, exp_v_data, exp_h_data;
    logic        pat [18];
    int          last_ack [2];
    int          exp_c [2];
    int          nack [2];
    logic [15:0] exp_d [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk100);
        cyc++;
    endtask

    function automatic logic [31:0] strb0();
        return 32'({b0.ram_ce, b0.ram_oe, b0.ram_we, b0.ram_lb, b0.ram_hb});
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] be);
        return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
    endfunction

    // One uncontested host transaction with cycle-exact checks.
    task automatic host_op(input logic we, input logic [17:0] a, input logic [15:0] d,
                           input logic [1:0] be, input string tag);
        int          k;
        logic [4:0]  e;
        logic [15:0] expd;
        b0.host_req   = 1'b1;
        b0.host_we    = we;
        b0.host_addr  = a;
        b0.host_wdata = d;
        b0.host_be    = be;
        k = 0;
        do begin step(); k++; end while (!b0.host_ack && k < 20);
        chk({tag, "_ack_lat"}, 32'(k), 32'd1);
        b0.host_req = 1'b0;
        if (we && be == 2'b00) e = 5'b00000;
        else if (we)           e = {3'b101, be[0], be[1]};
        else                   e = 5'b11011;
        expd = shadow[a[4:0]];
        if (we) shadow[a[4:0]] = merge(shadow[a[4:0]], d, be);
        for (int i = 0; i < AC; i++) begin
            if (i > 0) step();
            chk({tag, "_strobes"}, strb0(), 32'(e));
            if (e != 5'b00000) chk({tag, "_addr"}, 32'(b0.ram_addr), 32'(a));
            if (e[2]) chk({tag, "_dout"}, 32'(b0.ram_dout), 32'(d));
            chk({tag, "_rvalid_early"}, 32'(b0.host_rvalid), 32'd0);
        end
        step();
        chk({tag, "_turnaround"}, strb0(), 32'd0);
        chk({tag, "_rvalid"}, 32'(b0.host_rvalid), 32'(!we));
        if (!we) chk({tag, "_rdata"}, 32'(b0.host_rdata), 32'(expd));
        $display("host_op %s we=%0d addr=%0h wdata=%0h be=%0b rdata=%0h", tag, we, a, d, be, b0.host_rdata);
    endtask

    initial begin
        b0.vid_req = 1'b0; b0.vid_addr = '0;
        b0.host_req = 1'b0; b0.host_we = 1'b0; b0.host_addr = '0;
        b0.host_wdata = '0; b0.host_be = 2'b00;
        req_a[0] = 1'b0; req_a[1] = 1'b0; addr_a[0] = '0; addr_a[1] = '0;

        // Reset state
        repeat (3) step();
        chk("rst_ctl", 32'({b0.vid_ack, b0.vid_rvalid, b0.host_ack, b0.host_rvalid}), 32'd0);
        chk("rst_strobes", strb0(), 32'd0);
        chk("rst_addr", 32'(b0.ram_addr), 32'd0);
        chk("rst_dout", 32'(b0.ram_dout), 32'd0);
        chk("rst_rdata", 32'({b0.vid_rdata, b0.host_rdata}), 32'd0);
        reset_n = 1'b1;
        step();

        // Fill the SRAM with known contents
        for (int i = 0; i < 32; i++) host_op(1'b1, 18'(i), 16'($urandom), 2'b11, "init");

        // Full-word write then read back
        host_op(1'b1, 18'h00010, 16'hA55A, 2'b11, "wr_full");
        host_op(1'b0, 18'h00010, 16'h0000, 2'b00, "rd_full");
        chk("rd_full_const", 32'(b0.host_rdata), 32'h0000A55A);

        // Byte-lane write, then a write with no lanes
        host_op(1'b1, 18'h00011, 16'hFFFF, 2'b11, "wr_ffff");
        host_op(1'b1, 18'h00011, 16'h1234, 2'b01, "wr_lane0");
        host_op(1'b0, 18'h00011, 16'h0000, 2'b00, "rd_lane0");
        chk("rd_lane0_const", 32'(b0.host_rdata), 32'h0000FF34);
        host_op(1'b1, 18'h00011, 16'h9999, 2'b00, "wr_be00");
        host_op(1'b0, 18'h00011, 16'h0000, 2'b00, "rd_after_be00");
        chk("rd_after_be00_const", 32'(b0.host_rdata), 32'h0000FF34);

        // Simultaneous requests: video first, host on the next grant
        b0.vid_req = 1'b1; b0.vid_addr = 18'd3;
        b0.host_req = 1'b1; b0.host_we = 1'b0; b0.host_addr = 18'd4;
        step();
        chk("simul_first", 32'({b0.vid_ack, b0.host_ack}), 32'b10);
        b0.vid_req = 1'b0;
        m = 0;
        do begin step(); m++; end while (!b0.host_ack && m < 20);
        chk("simul_host_gap", 32'(m), 32'd3);
        b0.host_req = 1'b0;
        $display("simul: host_ack %0d cycles after vid_ack", m);
        repeat (AC + 1) step();

        // Starvation limit with continuous video and a held host request
        b0.vid_req = 1'b1; b0.vid_addr = 18'd0;
        b0.host_req = 1'b1; b0.host_we = 1'b0; b0.host_addr = 18'd5;
        got = 0; n = 0;
        while (got < 18 && n < 200) begin
            step(); n++;
            if (b0.vid_ack && got < 18) begin pat[got] = 1'b0; got++; b0.vid_addr = 18'((b0.vid_addr + 1) % 32); end
            if (b0.host_ack && got < 18) begin pat[got] = 1'b1; got++; end
        end
        chk("burst_grants", 32'(got), 32'd18);
        for (int i = 0; i < 18; i++) chk($sformatf("burst_pat%0d", i), 32'(pat[i]), 32'((i % 9) == 8));
        b0.vid_req = 1'b0; b0.host_req = 1'b0;
        repeat (AC + 2) step();

        // Reset in the middle of a video read once the host is owed a grant
        b0.vid_req = 1'b1; b0.vid_addr = 18'd7;
        b0.host_req = 1'b1; b0.host_we = 1'b0; b0.host_addr = 18'd8;
        nv = 0; nh = 0; n = 0;
        while (nv < 8 && n < 100) begin
            step(); n++;
            if (b0.vid_ack) nv++;
            if (b0.host_ack) nh++;
        end
        chk("rstmid_pre_vacks", 32'(nv), 32'd8);
        chk("rstmid_pre_hacks", 32'(nh), 32'd0);
        step();
        chk("rstmid_ce_before", 32'(b0.ram_ce), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_async_strobes", strb0(), 32'd0);
        step();
        chk("rstmid_no_rvalid", 32'({b0.vid_rvalid, b0.host_rvalid}), 32'd0);
        reset_n = 1'b1;
        step();
        chk("rstmid_regrant_video", 32'({b0.vid_ack, b0.host_ack}), 32'b10);
        chk("rstmid_no_rvalid2", 32'(b0.vid_rvalid), 32'd0);
        b0.vid_req = 1'b0; b0.host_req = 1'b0;
        repeat (AC + 2) step();

        // Randomized traffic against shadow memory and access windows
        streak = 0; win_end = -1; exp_v_cyc = -1; exp_h_cyc = -1;
        win_s = '0; win_addr = '0; win_dout = '0; exp_v_data = '0; exp_h_data = '0;
        for (int c = 0; c < 800; c++) begin
            step();
            chk("r_both_ack", 32'(b0.vid_ack & b0.host_ack), 32'd0);
            if (b0.vid_ack) begin
                chk("r_vid_req", 32'(b0.vid_req), 32'd1);
                if (b0.host_req) begin
                    chk("r_vid_starve", 32'(streak < MAXB), 32'd1);
                    streak++;
                end
                win_end = cyc + AC - 1; win_s = 5'b11011; win_addr = b0.vid_addr;
                exp_v_cyc = cyc + AC; exp_v_data = shadow[b0.vid_addr[4:0]];
                $display("rand cyc=%0d vid_ack addr=%0h streak=%0d", cyc, b0.vid_addr, streak);
                b0.vid_req = 1'b0;
            end
            if (b0.host_ack) begin
                chk("r_host_req", 32'(b0.host_req), 32'd1);
                if (b0.vid_req) chk("r_host_turn", 32'(streak), 32'(MAXB));
                streak = 0;
                if (!(b0.host_we && b0.host_be == 2'b00)) begin
                    win_end = cyc + AC - 1; win_addr = b0.host_addr; win_dout = b0.host_wdata;
                    if (b0.host_we) begin
                        win_s = {3'b101, b0.host_be[0], b0.host_be[1]};
                        shadow[b0.host_addr[4:0]] = merge(shadow[b0.host_addr[4:0]], b0.host_wdata, b0.host_be);
                    end else begin
                        win_s = 5'b11011;
                        exp_h_cyc = cyc + AC; exp_h_data = shadow[b0.host_addr[4:0]];
                    end
                end
                $display("rand cyc=%0d host_ack we=%0d addr=%0h be=%0b", cyc, b0.host_we, b0.host_addr, b0.host_be);
                b0.host_req = 1'b0;
            end
            es = (cyc <= win_end) ? win_s : 5'b00000;
            chk("r_strobes", strb0(), 32'(es));
            if (cyc <= win_end) begin
                chk("r_addr", 32'(b0.ram_addr), 32'(win_addr));
                if (win_s[2]) chk("r_dout", 32'(b0.ram_dout), 32'(win_dout));
            end
            chk("r_vid_rvalid", 32'(b0.vid_rvalid), 32'(cyc == exp_v_cyc));
            if (cyc == exp_v_cyc) chk("r_vid_rdata", 32'(b0.vid_rdata), 32'(exp_v_data));
            chk("r_host_rvalid", 32'(b0.host_rvalid), 32'(cyc == exp_h_cyc));
            if (cyc == exp_h_cyc) chk("r_host_rdata", 32'(b0.host_rdata), 32'(exp_h_data));
            if (!b0.vid_req && $urandom_range(0, 3) != 0) begin
                b0.vid_req = 1'b1; b0.vid_addr = 18'($urandom_range(0, 31));
            end
            if (!b0.host_req && $urandom_range(0, 3) == 0) begin
                b0.host_req = 1'b1; b0.host_we = 1'($urandom_range(0, 1));
                b0.host_addr = 18'($urandom_range(0, 31)); b0.host_wdata = 16'($urandom);
                b0.host_be = 2'($urandom_range(0, 3));
            end
        end
        b0.vid_req = 1'b0; b0.host_req = 1'b0;
        repeat (AC + 2) step();

        // Back-to-back video reads on the ACCESS_CYCLES = 1 and 4 instances
        for (int k = 0; k < 2; k++) begin
            req_a[k] = 1'b1; addr_a[k] = 18'(k * 100); last_ack[k] = -1; exp_c[k] = -1; nack[k] = 0;
            exp_d[k] = '0;
        end
        for (int c = 0; c < 40; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                int ac;
                ac = (k == 0) ? 1 : 4;
                chk($sformatf("ac%0d_rvalid", ac), 32'(rv[k]), 32'(cyc == exp_c[k]));
                if (cyc == exp_c[k]) chk($sformatf("ac%0d_rdata", ac), 32'(rd[k]), 32'(exp_d[k]));
                if (ackv[k]) begin
                    if (last_ack[k] >= 0) chk($sformatf("ac%0d_spacing", ac), 32'(cyc - last_ack[k]), 32'(ac + 1));
                    $display("ac%0d cyc=%0d vid_ack addr=%0h", ac, cyc, addr_a[k]);
                    last_ack[k] = cyc; exp_c[k] = cyc + ac;
                    exp_d[k] = addr_a[k][15:0] ^ 16'hC3C3;
                    addr_a[k] = addr_a[k] + 18'd1;
                    nack[k]++;
                end
            end
        end
        chk("ac1_count", 32'(nack[0] >= 19), 32'd1);
        chk("ac4_count", 32'(nack[1] >= 7), 32'd1);
        req_a[0] = 1'b0; req_a[1] = 1'b0;
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
